// File: rtl/dsc_pkg.sv
// Shared VGA timing defaults, text-grid geometry and sync bundle for the text scan generator.
// Default raster is 640x480@60 (800x525 totals), giving an 80x30 grid of 8x16 glyph cells.
package dsc_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int SYM_W     = 8;
    localparam int SYM_H     = 16;
    localparam int COLS      = DEF_H_ACTIVE / SYM_W;
    localparam int ROWS      = DEF_V_ACTIVE / SYM_H;
    localparam int TXT_DEPTH = COLS * ROWS;
    localparam int TXT_AW    = 12;
    localparam int CNT_W     = 10;

    localparam logic [7:0] SPACE = 8'h20;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port text buffer, registered read-first output, 1-cycle read latency.
// No backpressure: one write and one read per cycle; out-of-range writes are dropped.
module text_ram
    import dsc_pkg::*;
#(
    parameter int DEPTH = TXT_DEPTH
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [TXT_AW-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [TXT_AW-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam int IW = $clog2(DEPTH);

    // Cells hold ascii XOR space, so the all-zero power-up image reads back as blanks.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < TXT_AW'(DEPTH))) begin
            mem[wr_addr[IW-1:0]] <= wr_data ^ SPACE;
        end
        if (rd_en && (rd_addr < TXT_AW'(DEPTH))) begin
            rd_data <= mem[rd_addr[IW-1:0]] ^ SPACE;
        end
    end

endmodule

// File: rtl/text_scan_gen.sv
// VGA raster + text-buffer walker feeding the glyph ROM; ascii/pix 1 cycle, syncs/de 2 cycles.
// No backpressure: raster free-runs and text writes are accepted every cycle.
module text_scan_gen
    import dsc_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [TXT_AW-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        ascii,
    output logic [2:0]        pix_x,
    output logic [3:0]        pix_y,
    output logic              hsync,
    output logic              vsync,
    output logic              de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int N_COLS  = H_ACTIVE / SYM_W;
    localparam int N_ROWS  = V_ACTIVE / SYM_H;

    localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0]  HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0]  VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0]  VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [TXT_AW-1:0] COL_STEP = TXT_AW'(N_COLS);

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic [TXT_AW-1:0] line_base;
    logic [TXT_AW-1:0] rd_addr;
    logic [7:0]        ram_q;
    logic              h_last;
    logic              v_last;
    logic              active;
    sync_t             sync0;
    sync_t             sync1;
    sync_t             sync2;

    assign h_last  = (h_cnt == H_LAST);
    assign v_last  = (v_cnt == V_LAST);
    assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign rd_addr = line_base + TXT_AW'(h_cnt[CNT_W-1:3]);

    assign sync0 = '{hs: !in_window(h_cnt, HS_BEG, HS_END),
                     vs: !in_window(v_cnt, VS_BEG, VS_END),
                     de: active};

    // line_base steps by one text row after the last scanline of each glyph row.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            line_base <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) begin
                if (v_last) begin
                    v_cnt     <= '0;
                    line_base <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                    if ((v_cnt[3:0] == 4'hF) && (v_cnt < V_ACT)) begin
                        line_base <= line_base + COL_STEP;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_x <= '0;
            pix_y <= '0;
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
        end else begin
            pix_x <= active ? h_cnt[2:0] : 3'd0;
            pix_y <= active ? v_cnt[3:0] : 4'd0;
            sync1 <= sync0;
            sync2 <= sync1;
        end
    end

    text_ram #(
        .DEPTH(N_COLS * N_ROWS)
    ) u_text_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (active),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // The RAM output register is not reset; sync1.de (stage-1 active) masks it to blank.
    assign ascii = sync1.de ? ram_q : SPACE;
    assign hsync = sync2.hs;
    assign vsync = sync2.vs;
    assign de    = sync2.de;

endmodule

// File: tb/tb_text_scan_gen.sv
// Scoreboard bench: driver pushes position-derived expectations, monitor pops after each edge.
// Runs a reduced raster so several frames and a mid-frame reset fit in a short run.
module tb_text_scan_gen;

    localparam int HA  = 64;
    localparam int HFP = 8;
    localparam int HS  = 12;
    localparam int HBP = 12;
    localparam int VA  = 48;
    localparam int VFP = 3;
    localparam int VS  = 2;
    localparam int VBP = 4;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int NCOL  = HA / 8;
    localparam int NROW  = VA / 16;
    localparam int DEPTH = NCOL * NROW;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  ascii;
    logic [2:0]  pix_x;
    logic [3:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        de;

    always #5 clk = ~clk;

    text_scan_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ascii   (ascii),
        .pix_x   (pix_x),
        .pix_y   (pix_y),
        .hsync   (hsync),
        .vsync   (vsync),
        .de      (de)
    );

    typedef struct {
        logic [7:0] ascii;
        logic [2:0] px;
        logic [3:0] py;
        logic       hs;
        logic       vs;
        logic       de;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] txt [DEPTH];
    int         vectors     = 0;
    int         miscompares = 0;
    int         k           = 0;
    bit         done5       = 0;

    function automatic exp_t reset_exp();
        exp_t e;
        e.ascii = 8'h20; e.px = 3'd0; e.py = 4'd0;
        e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
        return e;
    endfunction

    // Expected outputs after the kk-th clock edge since reset release.
    function automatic exp_t exp_for(int kk);
        exp_t e;
        int   q, h, v;
        e = reset_exp();
        if (kk >= 1) begin
            q = kk - 1; h = q % HT; v = (q / HT) % VT;
            if (h < HA && v < VA) begin
                e.ascii = txt[(v / 16) * NCOL + h / 8];
                e.px    = 3'(h % 8);
                e.py    = 4'(v % 16);
            end
        end
        if (kk >= 2) begin
            q = kk - 2; h = q % HT; v = (q / HT) % VT;
            e.hs = !(h >= HA + HFP && h < HA + HFP + HS);
            e.vs = !(v >= VA + VFP && v < VA + VFP + VS);
            e.de = (h < HA) && (v < VA);
        end
        return e;
    endfunction

    task automatic check(input string name, input exp_t e);
        vectors++;
        if (ascii !== e.ascii || pix_x !== e.px || pix_y !== e.py ||
            hsync !== e.hs || vsync !== e.vs || de !== e.de) begin
            miscompares++;
            $display("FAIL %s t=%0t got ascii=%h px=%0d py=%0d hs=%b vs=%b de=%b want ascii=%h px=%0d py=%0d hs=%b vs=%b de=%b",
                     name, $time, ascii, pix_x, pix_y, hsync, vsync, de,
                     e.ascii, e.px, e.py, e.hs, e.vs, e.de);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) check("scoreboard", sb.pop_front());
    end

    task automatic run_cycle(input bit rst);
        int q, h, v, ra, r, a;
        bit act, we, was;
        logic [7:0] d;
        @(negedge clk);
        we = 1'b0; a = 0; d = 8'h00;
        if (!rst) begin
            was    = resetn;
            resetn = 1'b0;
            k      = 0;
            if (was) begin
                #1;
                check("reset_immediate", reset_exp());
            end
            sb.push_back(reset_exp());
        end else begin
            resetn = 1'b1;
            k++;
            q   = k - 1; h = q % HT; v = (q / HT) % VT;
            act = (h < HA) && (v < VA);
            ra  = act ? (v / 16) * NCOL + h / 8 : -1;
            r   = $urandom_range(0, 15);
            if (act && !done5 && (q / FRAME) == 1 && ra == 5) begin
                we = 1'b1; a = 5; d = 8'h33; done5 = 1'b1;
            end else if (k == 1) begin
                we = 1'b1; a = 0; d = 8'h41;
            end else if (k == 2) begin
                we = 1'b1; a = NCOL + 1; d = 8'h42;
            end else if (k == 3) begin
                we = 1'b1; a = DEPTH - 1; d = 8'h5A;
            end else if (k == 4) begin
                we = 1'b1; a = DEPTH; d = 8'h31;
            end else if (r < 2) begin
                we = 1'b1; a = $urandom_range(6, DEPTH + 7); d = 8'($urandom_range(33, 126));
            end else if (r == 2) begin
                we = 1'b1; a = $urandom_range(0, 4095); d = 8'($urandom_range(33, 126));
            end else if (r == 3 && act) begin
                we = 1'b1; a = ra; d = 8'($urandom_range(33, 126));
            end
            sb.push_back(exp_for(k));
            if (we && a < DEPTH) txt[a] = d;
        end
        wr_en   = we;
        wr_addr = 12'(a);
        wr_data = d;
    endtask

    initial begin
        resetn  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < DEPTH; i++) txt[i] = 8'h20;
        repeat (4) run_cycle(1'b0);
        repeat (2 * FRAME + 20 * HT + 30) run_cycle(1'b1);
        repeat (3) run_cycle(1'b0);
        repeat (FRAME + 10) run_cycle(1'b1);
        @(negedge clk);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
